// File: rtl/decoder_n_scan.sv
// N-to-2**N registered one-hot decoder with an automatic scan mode that
// walks every output once, then pulses done for a single cycle.
module decoder_n_scan #(
  parameter int N = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [N-1:0]      in,
  input  logic              sweep_start,
  output logic [2**N-1:0]   d,
  output logic              valid,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              done
);
  localparam int W = 2**N;
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [N-1:0] LAST = N'(W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] d_q, d_d;
  logic [N-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    d_d     = '0;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        // A sweep request outranks direct decode; in is ignored that cycle.
        if (sweep_start) begin
          state_d = S_SWEEP;
          d_d     = ONE;
          idx_d   = '0;
        end else if (en) begin
          d_d   = ONE << in;
          idx_d = in;
        end
      end
      S_SWEEP: begin
        // Leave before idx can wrap, so d stays zero in DONE.
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + N'(1);
          d_d   = ONE << idx_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
    end
  end

  assign d     = d_q;
  assign idx   = idx_q;
  assign valid = |d_q;
  assign busy  = (state_q == S_SWEEP) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: directed scenarios plus randomized traffic on an
// N=3 and an N=5 instance, checked against a sweep-position reference model.
module tb_decoder_n_scan;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0, sweep_start = 1'b0;
  logic [2:0] in3 = '0;
  logic [4:0] in5 = '0;
  logic [7:0] d3;
  logic [31:0] d5;
  logic [2:0] idx3;
  logic [4:0] idx5;
  logic valid3, busy3, done3, valid5, busy5, done5;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  decoder_n_scan #(.N(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .en(en), .in(in3), .sweep_start(sweep_start),
    .d(d3), .valid(valid3), .idx(idx3), .busy(busy3), .done(done3));

  decoder_n_scan #(.N(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .en(en), .in(in5), .sweep_start(sweep_start),
    .d(d5), .valid(valid5), .idx(idx5), .busy(busy5), .done(done5));

  // Reference model: a sweep is 2**N+1 busy cycles; position p = cycles since
  // acceptance (p < 2**N drives bit p, p == 2**N is the done cycle).
  int          nsel [2] = '{3, 5};
  logic [31:0] md   [2];
  int          midx [2];
  int          mleft[2];
  bit          mdone[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = '0; midx[k] = 0; mleft[k] = 0; mdone[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(int k, bit ss, bit e, int sel);
    int n = 1 << nsel[k];
    int p;
    bit sweeping = 1'b1;
    if (mleft[k] > 0) mleft[k]--;
    else if (ss) mleft[k] = n + 1;
    else sweeping = 1'b0;
    md[k] = '0;
    mdone[k] = 1'b0;
    if (!sweeping) begin
      if (e) begin md[k] = 32'd1 << sel; midx[k] = sel; end
    end else if (mleft[k] > 0) begin
      p = n + 1 - mleft[k];
      if (p < n) begin md[k] = 32'd1 << p; midx[k] = p; end
      else mdone[k] = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step(0, sweep_start, en, int'(in3));
    model_step(1, sweep_start, en, int'(in5));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({d3, idx3, valid3, busy3, done3} !== 14'h0) begin
      errors++; $display("FAIL reset3 got %h exp 0", {d3, idx3, valid3, busy3, done3});
    end
    checks++;
    if ({d5, idx5, valid5, busy5, done5} !== 40'h0) begin
      errors++; $display("FAIL reset5 got %h exp 0", {d5, idx5, valid5, busy5, done5});
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; in3 = 3'(i);
      tick();
      exp = 8'd1 << i;
      checks++;
      if ({d3, idx3, valid3, busy3, done3} !== {exp, 3'(i), 3'b100}) begin
        errors++; $display("FAIL direct[%0d] got d=%h idx=%0d v=%b b=%b dn=%b exp d=%h idx=%0d",
                           i, d3, idx3, valid3, busy3, done3, exp, i);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if ({d3, idx3, valid3, busy3} !== {8'h00, 3'd7, 2'b00}) begin
      errors++; $display("FAIL direct_off got d=%h idx=%0d v=%b exp d=00 idx=7 v=0", d3, idx3, valid3);
    end
  endtask

  // Walks one N=3 sweep already started: checks 8 drive cycles, DONE, return to idle.
  task automatic check_sweep3(string tag);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({d3, idx3, valid3, busy3, done3} !== {8'd1 << c, 3'(c), 3'b110}) begin
        errors++; $display("FAIL %s[%0d] got d=%h idx=%0d v=%b b=%b dn=%b exp d=%h",
                           tag, c, d3, idx3, valid3, busy3, done3, 8'd1 << c);
      end
      tick();
    end
    checks++;
    if ({d3, valid3, busy3, done3} !== {8'h00, 3'b011}) begin
      errors++; $display("FAIL %s_done got d=%h v=%b b=%b dn=%b exp d=00 v=0 b=1 dn=1",
                         tag, d3, valid3, busy3, done3);
    end
    tick();
    checks++;
    if ({d3, busy3, done3} !== {8'h00, 2'b00}) begin
      errors++; $display("FAIL %s_idle got d=%h b=%b dn=%b exp 00 0 0", tag, d3, busy3, done3);
    end
  endtask

  task automatic test_sweep();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    check_sweep3("sweep");
  endtask

  task automatic test_priority();
    sweep_start = 1'b1; en = 1'b1; in3 = 3'd5;
    tick();
    sweep_start = 1'b0;
    checks++;
    if (d3 !== 8'h01) begin
      errors++; $display("FAIL priority got d=%h exp 01", d3);
    end
    for (int c = 1; c < 8; c++) begin
      in3 = 3'($urandom);
      sweep_start = 1'($urandom);
      tick();
      checks++;
      if (d3 !== (8'd1 << c)) begin
        errors++; $display("FAIL prio_hold[%0d] got d=%h exp %h", c, d3, 8'd1 << c);
      end
    end
    sweep_start = 1'b0; in3 = 3'd5;
    tick();
    checks++;
    if ({d3, done3} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL prio_done got d=%h dn=%b exp 00 1", d3, done3);
    end
    tick();
    checks++;
    if ({d3, busy3} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL prio_exit got d=%h b=%b exp 00 0", d3, busy3);
    end
    tick();
    checks++;
    if (d3 !== 8'h20) begin
      errors++; $display("FAIL prio_after got d=%h exp 20", d3);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_rearm();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      check_sweep3(r == 0 ? "rearm0" : "rearm1");
      if (r == 0) begin
        // check_sweep3 leaves us on the first idle cycle after DONE
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
      end
    end
  endtask

  task automatic test_midreset();
    bit saw_done = 1'b0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (d3 !== 8'h08) begin
      errors++; $display("FAIL midrst_pre got d=%h exp 08", d3);
    end
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({d3, valid3, busy3, done3} !== 11'h0) begin
      errors++; $display("FAIL midrst_async got d=%h v=%b b=%b dn=%b exp all 0", d3, valid3, busy3, done3);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      saw_done |= done3;
    end
    @(negedge clock);
    reset_n = 1'b1;
    en = 1'b1; in3 = 3'd2;
    tick();
    en = 1'b0;
    checks++;
    if ({saw_done, d3, idx3, valid3} !== {1'b0, 8'h04, 3'd2, 1'b1}) begin
      errors++; $display("FAIL midrst_after got done_seen=%b d=%h idx=%0d v=%b exp 0 04 2 1",
                         saw_done, d3, idx3, valid3);
    end
    tick();
  endtask

  task automatic test_n5();
    int drive_cycles = 0;
    bit onehot_ok = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checks++;
      if ({d5, idx5, busy5, done5} !== {32'd1 << c, 5'(c), 2'b10}) begin
        errors++; $display("FAIL n5[%0d] got d=%h idx=%0d b=%b dn=%b exp d=%h",
                           c, d5, idx5, busy5, done5, 32'd1 << c);
      end
      if ($countones(d5) == 1) drive_cycles++;
      else onehot_ok = 1'b0;
      tick();
    end
    checks++;
    if ({onehot_ok, drive_cycles, d5, done5, busy5} !== {1'b1, 32'd32, 32'h0, 2'b11}) begin
      errors++; $display("FAIL n5_done got onehot=%b cycles=%0d d=%h dn=%b b=%b exp 1 32 0 1 1",
                         onehot_ok, drive_cycles, d5, done5, busy5);
    end
    tick();
    checks++;
    if ({busy5, done5} !== 2'b00) begin
      errors++; $display("FAIL n5_idle got b=%b dn=%b exp 0 0", busy5, done5);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      en          = 1'($urandom);
      sweep_start = ($urandom_range(0, 9) == 0);
      in3         = 3'($urandom);
      in5         = 5'($urandom);
      tick();
      checks++;
      if ({d3, idx3, valid3, busy3, done3} !==
          {md[0][7:0], 3'(midx[0]), md[0] != 0, mleft[0] > 0, mdone[0]}) begin
        errors++; $display("FAIL rand3[%0d] got d=%h idx=%0d v=%b b=%b dn=%b exp d=%h idx=%0d b=%b dn=%b",
                           t, d3, idx3, valid3, busy3, done3, md[0][7:0], midx[0], mleft[0] > 0, mdone[0]);
      end
      checks++;
      if ({d5, idx5, valid5, busy5, done5} !==
          {md[1], 5'(midx[1]), md[1] != 0, mleft[1] > 0, mdone[1]}) begin
        errors++; $display("FAIL rand5[%0d] got d=%h idx=%0d v=%b b=%b dn=%b exp d=%h idx=%0d b=%b dn=%b",
                           t, d5, idx5, valid5, busy5, done5, md[1], midx[1], mleft[1] > 0, mdone[1]);
      end
      checks++;
      if ($countones(d3) > 1 || $countones(d5) > 1) begin
        errors++; $display("FAIL onehot[%0d] got d3=%h d5=%h exp at most one bit", t, d3, d5);
      end
    end
    en = 1'b0; sweep_start = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct();
    test_sweep();
    test_priority();
    test_rearm();
    test_midreset();
    test_n5();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the select width; the decoded output width is 2**N, derived internally and not overridable.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1, the direct-decode request, sampled in IDLE only.
REQ-005 The block SHALL have port in, input, N, the select code for direct decode.
REQ-006 The block SHALL have port sweep_start, input, 1, the request to walk all outputs in order, sampled in IDLE only.
REQ-007 The block SHALL have port d, output, 2**N, the registered one-hot decode; it is all-zero when no select is active.
REQ-008 The block SHALL have port valid, output, 1, asserted exactly when d is non-zero.
REQ-009 The block SHALL have port idx, output, N, the index currently driven on d; it holds its last value otherwise.
REQ-010 The block SHALL have port busy, output, 1, high while in SWEEP or DONE.
REQ-011 The block SHALL have port done, output, 1, a single-cycle pulse on sweep completion.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SWEEP and DONE.
REQ-013 IDLE transitions:
- sweep_start=1: next state SWEEP; next cycle d=1, idx=0, valid=1, busy=1.
- Else en=1: stay in IDLE; next cycle d = 1<<in, idx=in, valid=1.
- Else: next cycle d=0, valid=0, idx unchanged.
REQ-014 Direct decode latency SHALL be exactly 1 cycle; back-to-back en cycles SHALL produce back-to-back decodes with no bubble.
REQ-015 If sweep_start and en are both high in IDLE, sweep_start SHALL win, and in SHALL be ignored for that cycle.
REQ-016 SWEEP behaviour:
- Each cycle, idx increments by 1 and d = 1<<idx.
- When idx = 2**N-1 is on d, next state SWEEP->DONE.
- d SHALL be non-zero for exactly 2**N consecutive cycles.
REQ-017 DONE behaviour:
- d=0, valid=0, done=1, busy=1 for exactly one cycle.
- Next state DONE->IDLE unconditionally.
REQ-018 en and sweep_start SHALL be ignored in SWEEP and DONE; a sweep cannot be restarted or aborted except by reset.
REQ-019 d SHALL never have more than one bit set in any cycle, including at state transitions.
REQ-020 The idx increment SHALL be N bits wide; no wrap past 2**N-1 SHALL be visible on d because the transition to DONE occurs first.
REQ-021 A sweep SHALL occupy 2**N+1 busy cycles in total; a new sweep_start SHALL be accepted on the first IDLE cycle after DONE.

Reset
REQ-022 While reset_n=0, the block SHALL immediately, without a clock, force: state=IDLE, d=0, valid=0, idx=0, busy=0, done=0.
REQ-023 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release, the block SHALL be in IDLE and respond to the first sampled request.
REQ-024 The first rising edge with reset_n=1 SHALL sample inputs normally.

Verification
REQ-025 Direct sweep of codes (N=3): en=1, in=0..7 on successive cycles -> each following cycle d=0x01,0x02,...,0x80, idx=in, valid=1; then en=0 -> d=0x00, valid=0.
REQ-026 Full sweep (N=3): a one-cycle sweep_start pulse -> d=0x01..0x80 on 8 consecutive cycles, then d=0x00 with done=1, busy=1 for 9 cycles, then busy=0.
REQ-027 Priority: sweep_start=1 and en=1 with in=5 in the same cycle -> next d=0x01, never 0x20; en held high during the sweep has no effect on the sequence.
REQ-028 Mid-sweep reset: reset_n driven low between clock edges while d=0x08 -> d=0x00, busy=0, valid=0 before the next edge; done is never asserted; after release, en=1, in=2 -> d=0x04.
REQ-029 Parameter check with N=5: sweep -> 32 one-hot values 0x00000001..0x80000000, done at cycle 33; a one-hot check on d passes every cycle.
REQ-030 Re-arm: sweep_start applied on the first IDLE cycle after DONE -> a second full sweep with an identical sequence.
